fadd_fsub_pipe: RTL and testbench
=================================

# fadd_fsub_pipe

Parametrised, pipelined IEEE-754 floating-point adder/subtractor for the RISC-V FPU. It is the successor to the combinational single-precision add/sub unit, with these additions:
- configurable exponent and mantissa widths;
- a 3-stage pipeline with valid/ready handshake;
- full special-value handling (NaN, infinity, signed zero, subnormals);
- all five RISC-V rounding modes;
- accrued exception flags.

It sits in the FP execute stage between operand read and the FP writeback/fflags path.

## Interface
Parameters:
- EXP_W, default 8: exponent width.
- MAN_W, default 23: stored mantissa width, without the hidden bit.
- XLEN, default EXP_W+MAN_W+1: operand width. Must not be overridden independently.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit can accept an operation this cycle.
- frs1  in  XLEN  operand A.
- frs2  in  XLEN  operand B.
- Funct  in  1  0 = A+B, 1 = A−B.
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 are treated as RNE.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- frd  out  XLEN  result.
- fflags  out  5  {NV,DZ,OF,UF,NX}. DZ is always 0.

## Operation
- Transfer rules:
  - Accept when in_valid && in_ready.
  - Retire when out_valid && out_ready.
- S1 (unpack/align):
  - Classify each operand as zero, subnormal, normal, inf, qNaN or sNaN. A subnormal uses exponent 1 with hidden bit 0.
  - Effective sign of B = frs2[XLEN-1] ^ Funct.
  - Swap so that |A| ≥ |B|, comparing exponent then mantissa.
  - Right-shift B by the exponent difference, keeping guard, round and sticky bits.
  - If the difference exceeds MAN_W+3, B collapses entirely into sticky.
- S2 (add/normalise):
  - Effective add or subtract on an (MAN_W+4)-bit magnitude.
  - On carry-out: shift right 1, exponent +1, shifted-out bit ORed into sticky.
  - Otherwise: left-normalise by the leading-zero count, limited so the exponent never drops below 1. The result becomes subnormal if the limit is hit.
- S3 (round/pack):
  - Round per rm using guard/round/sticky and the result sign.
  - If mantissa rounding carries out, exponent +1.
  - Pack the result and compute fflags.
- Special cases, highest priority first:
  - Any NaN input: frd = canonical qNaN {0, all-ones exponent, 1, zeros}. NV is set if either input is sNaN.
  - inf ± inf with effective subtraction: canonical qNaN, NV.
  - Any other inf operand: that inf with its effective sign. Flags 0.
  - Exact-zero sum of operands with opposite effective signs: +0, or −0 when rm=RDN.
  - Exact-zero sum of operands with equal signs: that sign. For example, −0 + −0 = −0.
- Overflow (rounded exponent ≥ all-ones): sets OF|NX. The result depends on rm and sign:
  - RNE or RMM: ±inf.
  - RTZ: ±max-finite.
  - RDN: +max-finite for positive, −inf for negative.
  - RUP: +inf for positive, −max-finite for negative.
- Flags:
  - NX: any discarded bit is nonzero, or overflow occurred.
  - UF: NX && the result is tiny after rounding (the unbounded-exponent rounded magnitude is below the minimum normal).

## Timing
- Reset: all stage valid bits, out_valid, frd and fflags are 0; in_ready = 1. Reset mid-operation discards every in-flight operation with no output.
- Latency: an operation accepted at edge N presents out_valid at edge N+3 when not stalled. Throughput is 1 per cycle.
- Stage advance:
  - A stage register loads when it is empty or its contents advance this cycle.
  - S3 advances when out_ready is high.
  - in_ready = ~S1_valid || S1 advances. This is combinational from out_ready through the stage valids.
- Stall: with out_ready = 0, at most 3 operations are held; in_ready falls once all stages are full.
- Hold and ordering:
  - frd and fflags stay stable while out_valid && !out_ready.
  - Ordering is strictly FIFO.
  - No operation is dropped or duplicated.
- Simultaneous retire and accept with a full pipe: allowed. Every stage advances in the same cycle.
- Outputs are registered. No combinational path from frs1/frs2 to frd.

## Test plan
- 0x3F800000 + 0x40000000, RNE, out_ready = 1 → frd 0x40400000, fflags 0, out_valid exactly 3 cycles after accept.
- 0x3F800000 − 0x3F800000 (Funct = 1):
  - RNE → 0x00000000.
  - RDN → 0x80000000.
  - Flags 0 in both cases.
- Specials:
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, fflags 10000.
  - 0x7F800001 + 0x3F800000 → 0x7FC00000, fflags 10000.
  - 0x00000001 + 0x00000001 → 0x00000002, fflags 0.
- Overflow, 0x7F7FFFFF + 0x7F7FFFFF:
  - RNE → 0x7F800000, fflags 00101.
  - RTZ → 0x7F7FFFFF, fflags 00101.
- Rounding, 0x3F800000 + 0x33800000 (a tie):
  - RNE → 0x3F800000, NX.
  - RUP → 0x3F800001, NX.
  - 0x3F800000 + 0x33800001 with RNE → 0x3F800001, NX.
- Backpressure and reset:
  - Issue 5 back-to-back ops with out_ready = 0 → in_ready goes low after 3 accepts.
  - Release out_ready → all 5 results arrive in order, with no gaps while the inputs stay valid.
  - Assert rst with 2 ops in flight → out_valid = 0 immediately, and no stale result appears afterwards.

Source files
------------

// File: rtl/fadd_fsub_pipe_if.sv
// +----------------------------------------------------------------------+
// | fadd_fsub_pipe_if: operand/result handshake bundle for fadd_fsub_pipe |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface fadd_fsub_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] frs1;
    logic [XLEN-1:0] frs2;
    logic            Funct;
    logic [2:0]      rm;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] frd;
    logic [4:0]      fflags;

    modport master (
        output in_valid, frs1, frs2, Funct, rm, out_ready,
        input  in_ready, out_valid, frd, fflags
    );

    modport slave (
        input  in_valid, frs1, frs2, Funct, rm, out_ready,
        output in_ready, out_valid, frd, fflags
    );
endinterface

`default_nettype wire

// File: rtl/fadd_fsub_pipe.sv
// +----------------------------------------------------------------------+
// | fadd_fsub_pipe: 3-stage IEEE-754 add/sub, valid/ready, RISC-V rm/flags |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fadd_fsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int XLEN  = EXP_W + MAN_W + 1
) (
    input wire logic        clk,
    input wire logic        rst,
    fadd_fsub_pipe_if.slave bus
);

    localparam int W   = MAN_W + 4;
    localparam int LZW = $clog2(W + 1);
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [EXP_W:0]   ONE_E     = 1;
    localparam logic [EXP_W:0]   ALIGN_MAX = (EXP_W+1)'(MAN_W + 3);
    localparam logic [XLEN-1:0]  QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    function automatic logic [LZW-1:0] lzc(input logic [W-1:0] v);
        lzc = LZW'(W);
        for (int i = 0; i < W; i++) begin
            if (v[i]) lzc = LZW'(W - 1 - i);
        end
    endfunction

    function automatic logic rnd_up(input logic [2:0] mode, input logic sgn,
                                    input logic lsb, input logic g, input logic st);
        case (mode)
            RM_RTZ:  rnd_up = 1'b0;
            RM_RDN:  rnd_up = sgn & (g | st);
            RM_RUP:  rnd_up = ~sgn & (g | st);
            RM_RMM:  rnd_up = g;
            default: rnd_up = g & (st | lsb);
        endcase
    endfunction

    // Pipeline control: a stage loads when empty or when its occupant moves on
    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic w_load1, w_load2, w_load3;
    assign w_load3      = ~s3_valid_q | bus.out_ready;
    assign w_load2      = ~s2_valid_q | w_load3;
    assign w_load1      = ~s1_valid_q | w_load2;
    assign bus.in_ready = w_load1;

    // ---------------- S1: unpack / classify / swap / align ----------------
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff, ex, ey, diff;
    logic [MAN_W-1:0] ma, mb;
    logic [MAN_W:0]   siga, sigb, sigx, sigy;
    logic             sa, sb, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, swap;
    logic [2*W-1:0]   sh_full;

    logic             s1_sign_d, s1_sub_d, s1_spec_d, s1_snv_d;
    logic [EXP_W-1:0] s1_exp_d;
    logic [W-1:0]     s1_big_d, s1_small_d;
    logic [2:0]       s1_rm_d;
    logic [XLEN-1:0]  s1_sval_d;

    assign ea     = bus.frs1[XLEN-2 -: EXP_W];
    assign eb     = bus.frs2[XLEN-2 -: EXP_W];
    assign ma     = bus.frs1[MAN_W-1:0];
    assign mb     = bus.frs2[MAN_W-1:0];
    assign sa     = bus.frs1[XLEN-1];
    assign sb     = bus.frs2[XLEN-1] ^ bus.Funct;
    assign a_inf  = (ea == EXP_ONES) && (ma == '0);
    assign b_inf  = (eb == EXP_ONES) && (mb == '0);
    assign a_nan  = (ea == EXP_ONES) && (ma != '0);
    assign b_nan  = (eb == EXP_ONES) && (mb != '0);
    assign a_snan = a_nan && !ma[MAN_W-1];
    assign b_snan = b_nan && !mb[MAN_W-1];
    // Subnormals behave as exponent 1 with a clear hidden bit
    assign ea_eff = (ea == '0) ? EXP_W'(1) : ea;
    assign eb_eff = (eb == '0) ? EXP_W'(1) : eb;
    assign siga   = {ea != '0, ma};
    assign sigb   = {eb != '0, mb};
    assign swap   = {eb_eff, sigb} > {ea_eff, siga};

    always_comb begin
        ex         = swap ? eb_eff : ea_eff;
        ey         = swap ? ea_eff : eb_eff;
        sigx       = swap ? sigb : siga;
        sigy       = swap ? siga : sigb;
        diff       = ex - ey;
        sh_full    = {sigy, 3'b000, {W{1'b0}}} >> diff;
        s1_sign_d  = swap ? sb : sa;
        s1_sub_d   = sa ^ sb;
        s1_exp_d   = ex;
        s1_big_d   = {sigx, 3'b000};
        s1_rm_d    = (bus.rm > RM_RMM) ? RM_RNE : bus.rm;
        if ({1'b0, diff} > ALIGN_MAX) begin
            s1_small_d = {{(W-1){1'b0}}, |sigy};
        end else begin
            s1_small_d = {sh_full[2*W-1:W+1], sh_full[W] | (|sh_full[W-1:0])};
        end
        s1_spec_d = 1'b0;
        s1_sval_d = '0;
        s1_snv_d  = 1'b0;
        if (a_nan || b_nan) begin
            s1_spec_d = 1'b1;
            s1_sval_d = QNAN;
            s1_snv_d  = a_snan | b_snan;
        end else if (a_inf && b_inf && (sa != sb)) begin
            s1_spec_d = 1'b1;
            s1_sval_d = QNAN;
            s1_snv_d  = 1'b1;
        end else if (a_inf) begin
            s1_spec_d = 1'b1;
            s1_sval_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_spec_d = 1'b1;
            s1_sval_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic             s1_sign_q, s1_sub_q, s1_spec_q, s1_snv_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [W-1:0]     s1_big_q, s1_small_q;
    logic [2:0]       s1_rm_q;
    logic [XLEN-1:0]  s1_sval_q;

    // ---------------- S2: add / normalise ----------------
    logic [W:0]       sum;
    logic [LZW-1:0]   lz;
    logic [EXP_W:0]   lz_e, lim, shamt;
    logic             s2_sign_d, s2_zero_d;
    logic [EXP_W:0]   s2_exp_d;
    logic [W-1:0]     s2_mag_d;

    always_comb begin
        sum   = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                         : ({1'b0, s1_big_q} + {1'b0, s1_small_q});
        lz    = lzc(sum[W-1:0]);
        lz_e  = (EXP_W+1)'(lz);
        lim   = {1'b0, s1_exp_q} - ONE_E;
        // Left shift is capped so the exponent stops at 1 (subnormal result)
        shamt = (lz_e > lim) ? lim : lz_e;
        if (sum[W]) begin
            s2_mag_d = {sum[W:2], sum[1] | sum[0]};
            s2_exp_d = {1'b0, s1_exp_q} + ONE_E;
        end else begin
            s2_mag_d = sum[W-1:0] << shamt;
            s2_exp_d = {1'b0, s1_exp_q} - shamt;
        end
        s2_zero_d = (sum == '0);
        if (s2_zero_d && s1_sub_q) s2_sign_d = (s1_rm_q == RM_RDN);
        else                       s2_sign_d = s1_sign_q;
    end

    logic             s2_sign_q, s2_zero_q, s2_spec_q, s2_snv_q;
    logic [EXP_W:0]   s2_exp_q;
    logic [W-1:0]     s2_mag_q;
    logic [2:0]       s2_rm_q;
    logic [XLEN-1:0]  s2_sval_q;

    // ---------------- S3: round / pack / flags ----------------
    logic [MAN_W:0]   mant, mant2;
    logic [MAN_W+1:0] rnd;
    logic [EXP_W:0]   exp_r;
    logic [MAN_W-1:0] frac;
    logic [EXP_W-1:0] exp_f;
    logic             g, r, st, up, up2, nx, tiny, ovf, normal, to_inf;
    logic [XLEN-1:0]  frd_d;
    logic [4:0]       fflags_d;

    always_comb begin
        mant   = s2_mag_q[W-1:3];
        g      = s2_mag_q[2];
        r      = s2_mag_q[1];
        st     = s2_mag_q[0];
        up     = rnd_up(s2_rm_q, s2_sign_q, mant[0], g, r | st);
        rnd    = {1'b0, mant} + {{(MAN_W+1){1'b0}}, up};
        exp_r  = s2_exp_q + {{EXP_W{1'b0}}, rnd[MAN_W+1]};
        normal = rnd[MAN_W+1] | rnd[MAN_W];
        frac   = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        exp_f  = normal ? exp_r[EXP_W-1:0] : '0;
        ovf    = normal && (exp_r >= {1'b0, EXP_ONES});
        nx     = g | r | st;
        // Tininess after rounding with unbounded exponent: round one bit finer
        mant2  = s2_mag_q[W-2:2];
        up2    = rnd_up(s2_rm_q, s2_sign_q, s2_mag_q[2], s2_mag_q[1], s2_mag_q[0]);
        tiny   = ~s2_mag_q[W-1] & ~(s2_mag_q[W-2] & (&mant2) & up2);
        to_inf = (s2_rm_q == RM_RNE) || (s2_rm_q == RM_RMM) ||
                 ((s2_rm_q == RM_RDN) && s2_sign_q) || ((s2_rm_q == RM_RUP) && !s2_sign_q);
        frd_d    = {s2_sign_q, exp_f, frac};
        fflags_d = {3'b000, nx & tiny, nx};
        if (s2_spec_q) begin
            frd_d    = s2_sval_q;
            fflags_d = {s2_snv_q, 4'b0000};
        end else if (s2_zero_q) begin
            frd_d    = {s2_sign_q, {(XLEN-1){1'b0}}};
            fflags_d = 5'b00000;
        end else if (ovf) begin
            frd_d    = to_inf ? {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}}
                              : {s2_sign_q, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
            fflags_d = 5'b00101;
        end
    end

    logic [XLEN-1:0] frd_q;
    logic [4:0]      fflags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            frd_q      <= '0;
            fflags_q   <= '0;
        end else begin
            if (w_load1) s1_valid_q <= bus.in_valid;
            if (w_load2) s2_valid_q <= s1_valid_q;
            if (w_load3) begin
                s3_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    frd_q    <= frd_d;
                    fflags_q <= fflags_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load1 && bus.in_valid) begin
            s1_sign_q  <= s1_sign_d;
            s1_sub_q   <= s1_sub_d;
            s1_exp_q   <= s1_exp_d;
            s1_big_q   <= s1_big_d;
            s1_small_q <= s1_small_d;
            s1_rm_q    <= s1_rm_d;
            s1_spec_q  <= s1_spec_d;
            s1_sval_q  <= s1_sval_d;
            s1_snv_q   <= s1_snv_d;
        end
        if (w_load2 && s1_valid_q) begin
            s2_sign_q <= s2_sign_d;
            s2_zero_q <= s2_zero_d;
            s2_exp_q  <= s2_exp_d;
            s2_mag_q  <= s2_mag_d;
            s2_rm_q   <= s1_rm_q;
            s2_spec_q <= s1_spec_q;
            s2_sval_q <= s1_sval_q;
            s2_snv_q  <= s1_snv_q;
        end
    end

    assign bus.out_valid = s3_valid_q;
    assign bus.frd       = frd_q;
    assign bus.fflags    = fflags_q;

endmodule

`default_nettype wire

// File: tb/tb_fadd_fsub_pipe.sv
// +----------------------------------------------------------------------+
// | tb_fadd_fsub_pipe: directed scoreboard bench for fadd_fsub_pipe      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fadd_fsub_pipe;

    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fadd_fsub_pipe_if #(.XLEN(32)) bus ();

    fadd_fsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] frd;
        logic [4:0]  fl;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   ret_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Output monitor: every presented result is checked against the queue head
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("stray_out_valid", {31'b0, bus.out_valid}, 32'd0);
            end else begin
                check({sb[0].tag, ".frd"}, bus.frd, sb[0].frd);
                check({sb[0].tag, ".fflags"}, {27'b0, bus.fflags}, {27'b0, sb[0].fl});
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                    ret_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic f,
                         input logic [2:0] mode, input logic [31:0] e, input logic [4:0] fl,
                         input string tag);
        exp_t x;
        int   n;
        bit   acc;
        x.frd = e;
        x.fl  = fl;
        x.tag = tag;
        sb.push_back(x);
        bus.frs1     = a;
        bus.frs2     = b;
        bus.Funct    = f;
        bus.rm       = mode;
        bus.in_valid = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = (bus.in_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check({tag, ".accepted"}, {31'b0, acc}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, ".drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.frs1      = '0;
        bus.frs2      = '0;
        bus.Funct     = 1'b0;
        bus.rm        = RNE;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst.frd", bus.frd, 32'd0);
        check("rst.fflags", {27'b0, bus.fflags}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Latency counted in cycles: the handshake cycle is cycle 0
        issue(32'h3F800000, 32'h40000000, 1'b0, RNE, 32'h40400000, 5'b00000, "add_1_2");
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid === 1'b1) break;
        end
        check("latency", 32'(lat), 32'd3);
        drain("lat");

        issue(32'h3F800000, 32'h3F800000, 1'b1, RNE, 32'h00000000, 5'b00000, "sub_zero_rne");
        issue(32'h3F800000, 32'h3F800000, 1'b1, RDN, 32'h80000000, 5'b00000, "sub_zero_rdn");
        issue(32'h80000000, 32'h80000000, 1'b0, RNE, 32'h80000000, 5'b00000, "negzero_sum");
        issue(32'h7F800000, 32'h7F800000, 1'b1, RNE, 32'h7FC00000, 5'b10000, "inf_minus_inf");
        issue(32'h7F800001, 32'h3F800000, 1'b0, RNE, 32'h7FC00000, 5'b10000, "snan_in");
        issue(32'h00000001, 32'h00000001, 1'b0, RNE, 32'h00000002, 5'b00000, "subnormal_add");
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RNE, 32'h7F800000, 5'b00101, "ovf_rne");
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RTZ, 32'h7F7FFFFF, 5'b00101, "ovf_rtz");
        issue(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RDN, 32'hFF800000, 5'b00101, "ovf_neg_rdn");
        issue(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RUP, 32'hFF7FFFFF, 5'b00101, "ovf_neg_rup");
        issue(32'h3F800000, 32'h33800000, 1'b0, RNE, 32'h3F800000, 5'b00001, "tie_rne");
        issue(32'h3F800000, 32'h33800000, 1'b0, RUP, 32'h3F800001, 5'b00001, "tie_rup");
        issue(32'h3F800000, 32'h33800001, 1'b0, RNE, 32'h3F800001, 5'b00001, "above_tie_rne");
        issue(32'h3F800000, 32'h33800000, 1'b0, 3'd5, 32'h3F800000, 5'b00001, "tie_rm5");
        issue(32'h7F800000, 32'h3F800000, 1'b0, RNE, 32'h7F800000, 5'b00000, "inf_plus_one");
        issue(32'h3F800000, 32'h7F800000, 1'b1, RNE, 32'hFF800000, 5'b00000, "one_minus_inf");
        drain("directed");

        // Backpressure: three ops fill the pipe, then in_ready must drop
        bus.out_ready = 1'b0;
        ret_cyc.delete();
        issue(32'h3F800000, 32'h3F800000, 1'b0, RNE, 32'h40000000, 5'b00000, "bp1");
        issue(32'h3F800000, 32'h40000000, 1'b0, RNE, 32'h40400000, 5'b00000, "bp2");
        issue(32'h40000000, 32'h40000000, 1'b0, RNE, 32'h40800000, 5'b00000, "bp3");
        @(negedge clk);
        check("bp.in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bp.held_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        issue(32'h41000000, 32'h3F800000, 1'b1, RNE, 32'h40E00000, 5'b00000, "bp4");
        issue(32'h40800000, 32'h3F800000, 1'b0, RNE, 32'h40A00000, 5'b00000, "bp5");
        drain("bp");
        check("bp.retired", 32'(ret_cyc.size()), 32'd5);
        if (ret_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) begin
                check($sformatf("bp.gap%0d", i), 32'(ret_cyc[i] - ret_cyc[i-1]), 32'd1);
            end
        end

        // Reset with two operations in flight
        bus.out_ready = 1'b0;
        issue(32'h3F800000, 32'h3F800000, 1'b0, RNE, 32'h40000000, 5'b00000, "rst_op1");
        issue(32'h40000000, 32'h40000000, 1'b0, RNE, 32'h40800000, 5'b00000, "rst_op2");
        @(posedge clk);
        #1;
        check("pre_rst.out_valid", {31'b0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid.out_valid", {31'b0, bus.out_valid}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("post_rst.in_ready", {31'b0, bus.in_ready}, 32'd1);
        issue(32'h40400000, 32'h3F800000, 1'b0, RNE, 32'h40800000, 5'b00000, "post_rst_add");
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

`default_nettype wire
